baud_tick_gen: RTL and testbench



---
 rtl/baud_tick_gen.sv | 159 +++++++++++++++
 tb/tb_baud_tick_gen.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_tick_gen.sv
// Phase-accumulator baud tick generator with an oversampled tick, run-time
// baud reprogramming through a multicycle restoring divider, and phase resync.
module baud_tick_gen #(
  parameter int unsigned CLK_FREQ     = 25000000,
  parameter int unsigned ACC_WIDTH    = 16,
  parameter int unsigned OS_LOG2      = 4,
  parameter int unsigned DEFAULT_BAUD = 115200
) (
  input  logic        inclk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        sync,
  input  logic [31:0] baud,
  input  logic        load,
  output logic        busy,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic        tick_os,
  output logic        tick
);

  localparam int unsigned W     = ACC_WIDTH;
  localparam int unsigned AW    = W + 1;
  localparam int unsigned OS    = 1 << OS_LOG2;
  localparam int unsigned NUM_W = 32 + OS_LOG2 + W + 1;
  localparam int unsigned CW    = (OS_LOG2 == 0) ? 1 : OS_LOG2;
  localparam int unsigned DCW   = $clog2(NUM_W);

  localparam logic [CW-1:0] OS_LAST     = CW'(OS - 1);
  localparam logic [63:0]   DEF_Q       = (64'(DEFAULT_BAUD) << (OS_LOG2 + W + 1)) / 64'(CLK_FREQ);
  localparam logic [W:0]    DEFAULT_INC = AW'((DEF_Q + 64'd1) >> 1);
  localparam logic [32:0]   DIV33       = 33'(CLK_FREQ);
  localparam logic [31:0]   DIV32       = 32'(CLK_FREQ);
  localparam logic [63:0]   BAUD_MAX    = 64'(CLK_FREQ / 2);

  // state | meaning: IDLE waits for load, DIV one quotient bit per cycle, APPLY rounds and commits inc
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DIV   = 2'd1;
  localparam logic [1:0] S_APPLY = 2'd2;

  logic [W:0]       acc_q, acc_d;
  logic [CW-1:0]    os_cnt_q, os_cnt_d;
  logic             tick_os_q, tick_os_d;
  logic             tick_q, tick_d;
  logic [W:0]       inc_q, inc_d;
  logic [1:0]       state_q, state_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [31:0]      rem_q, rem_d;
  logic [DCW-1:0]   div_cnt_q, div_cnt_d;
  logic             cfg_done_q, cfg_done_d;
  logic             cfg_err_q, cfg_err_d;

  logic [W:0]  acc_sum;
  logic [63:0] baud_os;
  logic        baud_ok;
  logic [32:0] rem_sh;
  logic        rem_ge;
  logic [31:0] rem_sub;

  assign acc_sum = {1'b0, acc_q[W-1:0]} + inc_q;
  assign baud_os = {32'd0, baud} << OS_LOG2;
  assign baud_ok = (baud != 32'd0) && (baud_os <= BAUD_MAX);
  assign rem_sh  = {rem_q, num_q[NUM_W-1]};
  assign rem_ge  = rem_sh >= DIV33;
  // Partial remainder stays below the divisor, so 32 bits hold the difference.
  assign rem_sub = rem_sh[31:0] - DIV32;

  always_comb begin
    acc_d     = acc_q;
    os_cnt_d  = os_cnt_q;
    tick_os_d = 1'b0;
    tick_d    = 1'b0;
    if (sync) begin
      acc_d    = '0;
      os_cnt_d = '0;
    end else if (en) begin
      acc_d     = acc_sum;
      tick_os_d = acc_sum[W];
      if (acc_sum[W]) begin
        tick_d   = (os_cnt_q == OS_LAST);
        os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    rem_d      = rem_q;
    div_cnt_d  = div_cnt_q;
    inc_d      = inc_q;
    cfg_done_d = 1'b0;
    cfg_err_d  = cfg_err_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          if (baud_ok) begin
            num_d     = {baud, {(OS_LOG2 + W + 1){1'b0}}};
            rem_d     = '0;
            div_cnt_d = DCW'(NUM_W - 1);
            cfg_err_d = 1'b0;
            state_d   = S_DIV;
          end else begin
            cfg_done_d = 1'b1;
            cfg_err_d  = 1'b1;
          end
        end
      end
      S_DIV: begin
        rem_d = rem_ge ? rem_sub : rem_sh[31:0];
        num_d = {num_q[NUM_W-2:0], rem_ge};
        if (div_cnt_q == '0) state_d = S_APPLY;
        else                 div_cnt_d = div_cnt_q - 1'b1;
      end
      S_APPLY: begin
        // Round half up: (q+1)>>1 == q/2 + lsb(q).
        inc_d      = {1'b0, num_q[W:1]} + {{W{1'b0}}, num_q[0]};
        cfg_done_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge inclk) begin
    if (!rst_n) begin
      acc_q      <= '0;
      os_cnt_q   <= '0;
      tick_os_q  <= 1'b0;
      tick_q     <= 1'b0;
      inc_q      <= DEFAULT_INC;
      state_q    <= S_IDLE;
      num_q      <= '0;
      rem_q      <= '0;
      div_cnt_q  <= '0;
      cfg_done_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      os_cnt_q   <= os_cnt_d;
      tick_os_q  <= tick_os_d;
      tick_q     <= tick_d;
      inc_q      <= inc_d;
      state_q    <= state_d;
      num_q      <= num_d;
      rem_q      <= rem_d;
      div_cnt_q  <= div_cnt_d;
      cfg_done_q <= cfg_done_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign cfg_done = cfg_done_q;
  assign cfg_err  = cfg_err_q;
  assign tick_os  = tick_os_q;
  assign tick     = tick_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Bench for baud_tick_gen: cumulative-phase reference model compared every
// cycle, plus directed scenarios with hand-computed tick counts and latencies.
module tb_baud_tick_gen;

  localparam int     W       = 16;
  localparam int     OS_LOG2 = 4;
  localparam int     OS      = 16;
  localparam int     NUM_W   = 32 + OS_LOG2 + W + 1;
  localparam longint CLK     = 25000000;

  logic        inclk = 1'b0;
  logic        rst_n, en, sync, load;
  logic [31:0] baud;
  logic        busy, cfg_done, cfg_err, tick_os, tick;

  baud_tick_gen dut (
    .inclk    (inclk),
    .rst_n    (rst_n),
    .en       (en),
    .sync     (sync),
    .baud     (baud),
    .load     (load),
    .busy     (busy),
    .cfg_done (cfg_done),
    .cfg_err  (cfg_err),
    .tick_os  (tick_os),
    .tick     (tick)
  );

  always #5 inclk = ~inclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: total phase since last sync/reset; a tick_os is each
  // crossing of a multiple of 2**W, a tick is every OS-th such crossing.
  function automatic longint calc_inc(input longint b);
    return (((b << (OS_LOG2 + W + 1)) / CLK) + 1) >> 1;
  endfunction

  function automatic bit in_range(input longint b);
    return (b >= 1) && ((b << OS_LOG2) <= CLK / 2);
  endfunction

  longint m_total, m_inc, m_pend;
  int     m_nos, m_left;
  bit     e_busy, e_done, e_err, e_tos, e_tick;
  int     cyc_n = 0;
  bit     started = 0;

  task automatic model_step();
    longint nxt;
    longint b;
    cyc_n++;
    started = 1;
    if (!rst_n) begin
      m_total = 0; m_nos = 0; m_inc = calc_inc(115200); m_left = 0;
      e_busy = 0; e_done = 0; e_err = 0; e_tos = 0; e_tick = 0;
    end else begin
      e_done = 0;
      if (sync) begin
        m_total = 0; m_nos = 0; e_tos = 0; e_tick = 0;
      end else if (en) begin
        nxt = m_total + m_inc;
        e_tos = ((nxt >> W) != (m_total >> W));
        m_total = nxt;
        if (e_tos) m_nos++;
        e_tick = e_tos && (m_nos % OS == 0);
      end else begin
        e_tos = 0; e_tick = 0;
      end
      b = longint'({32'd0, baud});
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_inc = m_pend;
          e_done = 1;
        end
      end else if (load) begin
        if (in_range(b)) begin
          m_pend = calc_inc(b);
          m_left = NUM_W + 1;
          e_err = 0;
        end else begin
          e_done = 1;
          e_err = 1;
        end
      end
      e_busy = (m_left > 0);
    end
  endtask

  initial forever begin
    @(posedge inclk);
    model_step();
  end

  // Measurements taken from DUT outputs, cleared by the stimulus.
  int n_tos, n_tick, n_busy, n_done;
  int first_tos_cyc, last_tos_cyc, tos_first_tick, done_cyc;
  bit done_err;
  bit spacing_on = 0;

  task automatic clear_meas();
    n_tos = 0; n_tick = 0; n_busy = 0; n_done = 0;
    first_tos_cyc = -1; last_tos_cyc = -1; tos_first_tick = -1; done_cyc = -1;
    done_err = 0;
  endtask

  initial begin
    clear_meas();
    forever begin
      @(negedge inclk);
      if (started) begin
        n_checks++;
        if ({busy, cfg_done, cfg_err, tick_os, tick} !== {e_busy, e_done, e_err, e_tos, e_tick}) begin
          n_errors++;
          $display("FAIL cycle %0d outputs {busy,done,err,tos,tick}: got %b expected %b", cyc_n,
                   {busy, cfg_done, cfg_err, tick_os, tick}, {e_busy, e_done, e_err, e_tos, e_tick});
        end
        if (tick_os === 1'b1) begin
          n_tos++;
          if (first_tos_cyc < 0) first_tos_cyc = cyc_n;
          if (spacing_on && last_tos_cyc >= 0)
            check("tos_spacing_13_or_14", longint'((cyc_n - last_tos_cyc == 13) || (cyc_n - last_tos_cyc == 14)), 1);
          last_tos_cyc = cyc_n;
        end
        if (tick === 1'b1) begin
          n_tick++;
          if (tos_first_tick < 0) tos_first_tick = n_tos;
        end
        if (busy === 1'b1) n_busy++;
        if (cfg_done === 1'b1) begin
          n_done++;
          done_cyc = cyc_n;
          done_err = cfg_err;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge inclk);
    #1;
  endtask

  int r;

  initial begin
    rst_n = 1'b0; en = 1'b0; sync = 1'b0; load = 1'b0; baud = 32'd0;
    cyc(3);
    rst_n = 1'b1;
    check("reset_outputs", longint'({busy, cfg_done, cfg_err, tick_os, tick}), 0);

    // Default rate from reset: 16384*4832/65536 = 1208 tick_os, 75 ticks.
    en = 1'b1; clear_meas(); spacing_on = 1;
    cyc(16384);
    en = 1'b0;
    cyc(1);
    spacing_on = 0;
    check("default_tos_count", n_tos, 1208);
    check("default_tick_count", n_tick, 75);

    // Out-of-range load: 1e6*16 > 12.5e6.
    en = 1'b1; baud = 32'd1000000; load = 1'b1;
    cyc(1);
    load = 1'b0;
    check("err_done_pulse", cfg_done, 1);
    check("err_flag", cfg_err, 1);
    check("err_not_busy", busy, 0);
    cyc(1);
    check("err_done_one_cycle", cfg_done, 0);
    check("err_sticky", cfg_err, 1);
    sync = 1'b1;
    cyc(1);
    sync = 1'b0; clear_meas();
    cyc(8192);
    en = 1'b0;
    cyc(1);
    check("err_rate_unchanged_tos", n_tos, 604);
    check("err_rate_unchanged_tick", n_tick, 37);
    check("err_never_busy", n_busy, 0);
    check("err_still_sticky", cfg_err, 1);

    // Sync mid-stream: first tick_os 14 cycles later, first tick on the 16th.
    en = 1'b1;
    cyc(50);
    sync = 1'b1;
    cyc(1);
    sync = 1'b0; r = cyc_n; clear_meas();
    check("sync_clears_tos", tick_os, 0);
    check("sync_clears_tick", tick, 0);
    cyc(300);
    check("sync_first_tos_delay", first_tos_cyc - r, 14);
    check("sync_first_tick_index", tos_first_tick, 16);

    // en=0 freezes phase: 7 adds, 100 idle cycles, 7 more adds reach the carry.
    sync = 1'b1;
    cyc(1);
    sync = 1'b0;
    cyc(7);
    en = 1'b0; clear_meas();
    cyc(100);
    check("disabled_no_tos", n_tos, 0);
    check("disabled_no_tick", n_tick, 0);
    en = 1'b1; r = cyc_n; clear_meas();
    cyc(20);
    check("frozen_phase_resume", first_tos_cyc - r, 7);

    // Valid load 9600 (inc 403) with a second load while busy that must be ignored.
    baud = 32'd9600; load = 1'b1; r = cyc_n; clear_meas();
    cyc(1);
    load = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_clears_err", cfg_err, 0);
    cyc(9);
    baud = 32'd19200; load = 1'b1;
    cyc(1);
    load = 1'b0; baud = 32'd0;
    cyc(60);
    check("load_single_done", n_done, 1);
    check("load_done_latency", done_cyc - r, 55);
    check("load_done_no_err", done_err, 0);
    check("load_busy_cycles", n_busy, 54);
    sync = 1'b1;
    cyc(1);
    sync = 1'b0; clear_meas();
    cyc(16384);
    en = 1'b0;
    cyc(1);
    check("baud9600_tos_count", n_tos, 100);
    check("baud9600_tick_count", n_tick, 6);

    // Reset during DIV aborts the load and restores the default increment.
    en = 1'b1; baud = 32'd57600; load = 1'b1;
    cyc(1);
    load = 1'b0;
    cyc(20);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    check("rst_div_not_busy", busy, 0);
    check("rst_div_no_done", cfg_done, 0);
    clear_meas();
    cyc(8192);
    en = 1'b0;
    cyc(1);
    check("rst_div_no_later_done", n_done, 0);
    check("rst_div_no_later_busy", n_busy, 0);
    check("rst_div_default_rate", n_tos, 604);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
